// File: rtl/leaf_out_packetizer_if.sv
// Purpose: bundles the user stream, destination config, credit return and
//          BFT packet output of one leaf output packetizer.
// Ports:   master = kernel/config/downstream side, slave = packetizer.
interface leaf_out_packetizer_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7
);
  logic [PAYLOAD_BITS-1:0]  din_user;
  logic                     vld_user;
  logic                     ack_user;
  logic                     cfg_wr;
  logic [NUM_LEAF_BITS-1:0] cfg_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_port;
  logic                     freespace_upd;
  logic [PACKET_BITS-1:0]   pkt_out;
  logic                     pkt_rdy;
  logic [NUM_ADDR_BITS:0]   credit_cnt;
  logic                     credit_err;

  modport master (
    output din_user, vld_user, cfg_wr, cfg_leaf, cfg_port, freespace_upd, pkt_rdy,
    input  ack_user, pkt_out, credit_cnt, credit_err
  );

  modport slave (
    input  din_user, vld_user, cfg_wr, cfg_leaf, cfg_port, freespace_upd, pkt_rdy,
    output ack_user, pkt_out, credit_cnt, credit_err
  );
endinterface

// File: rtl/leaf_out_packetizer.sv
// Purpose: wraps 32-bit user words into 49-bit BFT packets {vld,leaf,port,addr,payload}
//          sent to a configured leaf/port at a running BRAM slot address, credit-gated.
// Latency: 1 cycle from user accept to pkt_out when the buffer is empty (bypass path).
// Backpressure: pkt_out holds while pkt_rdy=0; ack_user drops when the 4-entry buffer
//          is full; no packet is loaded while credit_cnt is zero.
// Ports:   clk, reset (sync, active-high); io = leaf_out_packetizer_if.slave
//          (user stream, cfg_wr/leaf/port, freespace_upd, pkt_out/pkt_rdy, credit_cnt/err).
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  leaf_out_packetizer_if.slave io
);
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int CR_BITS  = NUM_ADDR_BITS + 1;
  // One bit of headroom so credit + update can be compared against the cap.
  localparam int SUM_BITS = NUM_ADDR_BITS + 2;
  localparam logic [CR_BITS-1:0]  CREDIT_MAX   = {1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [SUM_BITS-1:0] CREDIT_MAX_W = {1'b0, CREDIT_MAX};
  localparam logic [SUM_BITS-1:0] UPD_INC      = SUM_BITS'(FREESPACE_UPDATE_SIZE);

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  typedef enum logic {UNCFG, RUN} state_t;

  state_t                   state, state_nxt;
  logic                     cfg_load, ack;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic [CR_BITS-1:0]       credit_q;
  logic                     credit_err_q;
  pkt_t                     out_q;

  logic [PAYLOAD_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]      wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]      count;
  logic                     fifo_empty, fifo_full;
  logic                     push, load, bypass, wr_en, pop;
  logic [PAYLOAD_BITS-1:0]  head;
  logic [SUM_BITS-1:0]      credit_sum;
  logic                     credit_ovf;

  // Reconfiguring in RUN is only safe once nothing is in flight, otherwise
  // buffered words would leave with the new destination and a reset address.
  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    ack       = 1'b0;
    case (state)
      UNCFG: begin
        if (io.cfg_wr) begin
          cfg_load  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ack = !fifo_full;
        if (io.cfg_wr && fifo_empty && !out_q.vld) cfg_load = 1'b1;
      end
      default: state_nxt = UNCFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= UNCFG;
    else       state <= state_nxt;
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_BITS'(FIFO_DEPTH));
  assign push       = io.vld_user && ack;
  // An empty buffer forwards the incoming word straight to the output register.
  assign head       = fifo_empty ? io.din_user : mem[rd_ptr];
  // A reconfiguring cycle never loads, so the new fields and address 0 apply cleanly.
  assign load       = !cfg_load && (!out_q.vld || io.pkt_rdy) &&
                      (!fifo_empty || push) && (credit_q != '0);
  assign bypass     = load && fifo_empty;
  assign wr_en      = push && !bypass;
  assign pop        = load && !fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= io.din_user;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count + CNT_BITS'(wr_en) - CNT_BITS'(pop);
    end
  end

  always_comb begin
    credit_sum = {1'b0, credit_q};
    if (io.freespace_upd) credit_sum = credit_sum + UPD_INC;
    if (load)             credit_sum = credit_sum - SUM_BITS'(1);
    credit_ovf = (credit_sum > CREDIT_MAX_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leaf_q       <= '0;
      port_q       <= '0;
      addr_q       <= '0;
      credit_q     <= CREDIT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      if (cfg_load) begin
        leaf_q   <= io.cfg_leaf;
        port_q   <= io.cfg_port;
        addr_q   <= '0;
        credit_q <= CREDIT_MAX;
      end else begin
        if (load) addr_q <= addr_q + NUM_ADDR_BITS'(1);
        credit_q <= credit_ovf ? CREDIT_MAX : credit_sum[CR_BITS-1:0];
        if (credit_ovf) credit_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (load) begin
      out_q <= '{vld: 1'b1, leaf: leaf_q, port: port_q, addr: addr_q, payload: head};
    end else if (io.pkt_rdy) begin
      out_q <= '0;
    end
  end

  assign io.ack_user   = ack;
  assign io.pkt_out    = out_q;
  assign io.credit_cnt = credit_q;
  assign io.credit_err = credit_err_q;
endmodule

// File: doc/leaf_out_packetizer.md
Name: leaf_out_packetizer

Overview:
- Sits between one user-kernel output stream (Output_N_V) and the BFT-facing packet mux of a leaf page.
- Buffers 32-bit user words, wraps each one into a 49-bit BFT packet addressed to a configured destination leaf and port, and writes it to the destination's input BRAM at a running slot address.
- Sends only while credits remain. Each freespace update returned by the destination adds credits.

Parameters:
- PACKET_BITS, 49, packet width; equals 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, BRAM slot address field width.
- FREESPACE_UPDATE_SIZE, 64, credits added per freespace update pulse.
- FIFO_DEPTH, 4, input buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- din_user  in  PAYLOAD_BITS  user data word.
- vld_user  in  1  din_user valid.
- ack_user  out  1  buffer can accept; a transfer occurs when vld_user&ack_user.
- cfg_wr  in  1  one-cycle pulse that loads the destination fields.
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_port  in  NUM_PORT_BITS  destination port.
- freespace_upd  in  1  one-cycle pulse; adds FREESPACE_UPDATE_SIZE credits.
- pkt_out  out  PACKET_BITS  packet; bit 48 is the valid bit.
- pkt_rdy  in  1  downstream accepts pkt_out this cycle.
- credit_cnt  out  NUM_ADDR_BITS+1  current credits.
- credit_err  out  1  sticky overflow flag.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-high, and takes priority over all other inputs.
- Reset values:
  - ack_user=0, pkt_out=0, credit_cnt=2^NUM_ADDR_BITS (128), credit_err=0.
  - Slot address=0, FIFO empty, FSM=UNCFG.
- FSM:
  - UNCFG: ack_user=0. A cfg_wr pulse latches leaf/port and moves to RUN.
  - RUN: ack_user = FIFO not full (registered-free; may depend on the current FIFO count only).
  - A cfg_wr in RUN is accepted only when the FIFO is empty and no packet is pending. It reloads the fields, resets the slot address to 0 and credits to 128. Otherwise it is ignored.
- Packet format, MSB to LSB: {1'b1, leaf, port, addr, payload}.
- Output register:
  - Loads from the FIFO head when all three hold: the register is empty or being accepted (pkt_rdy), the FIFO is not empty, and credit_cnt>0.
  - Holds stable while bit48=1 and pkt_rdy=0.
  - Clears to 0 when accepted with nothing new to load.
- Latency:
  - Word accepted at cycle N appears on pkt_out at cycle N+1 when the FIFO was empty, credit>0 and the register was free. Full-rate one packet/cycle with pkt_rdy held high.
  - An accepted word is always delivered in order. Words are never dropped or duplicated.
- Slot address:
  - Increments by 1 mod 2^NUM_ADDR_BITS on each load into the output register.
  - Wraps 127→0.
- Credit arithmetic:
  - Decrement by 1 on each load into the output register.
  - Increment by FREESPACE_UPDATE_SIZE on freespace_upd.
  - Both in the same cycle: net +FREESPACE_UPDATE_SIZE−1.
  - If the result exceeds 128, saturate at 128 and set credit_err (sticky until reset).
- Credit zero: no load occurs. The FIFO fills, then ack_user drops. Flow resumes the cycle after freespace_upd.
- A freespace_upd in UNCFG still updates credits (saturating).
- Reset mid-operation: the FIFO contents and the pending packet are discarded, and all state returns to its reset values next cycle.

Test Plan:
- Basic send: reset, cfg_wr leaf=5, port=3; push 0xDEADBEEF with pkt_rdy=1 → next cycle pkt_out={1,5'd5,4'd3,7'd0,0xDEADBEEF}, credit_cnt=127.
- Streaming and wrap: push 130 words, with freespace_upd pulsed after word 64 and after word 128 → addr fields run 0..127,0,1, all payloads in order, credit_err=0.
- Credit exhaustion: 128 words sent without an update → the 129th word waits and ack_user=0 after 4 more words. One freespace_upd → the 129th packet issues with addr=0 the next cycle, credit_cnt=63.
- Backpressure: pkt_rdy=0 for 10 cycles while pushing 6 words → pkt_out is stable on the first packet, ack_user=0 after 4 buffered words. Release → the 6 packets issue in order on consecutive cycles.
- Simultaneous and overflow: at credit 100, freespace_upd coincides with a load → credit_cnt=128 and credit_err=1. At credit 50, the same coincidence → credit_cnt=113, no error.
- Reset mid-stream: assert reset with 3 words buffered and a packet pending → next cycle pkt_out=0, ack_user=0, credit_cnt=128. After cfg_wr, the first packet has addr=0.
